// File: rtl/front_end_mc_if.sv
// Handshake bundle between the burst sequencer and its host, input memory,
// core and output FIFOs.
interface front_end_mc_if #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic [N_CH-1:0]  ch_en;
    logic [N_CH-1:0]  full;
    logic             abort;
    logic             rden;
    logic [CNT_W-1:0] addr;
    logic             en;
    logic [N_CH-1:0]  wr;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, len, ch_en, full, abort,
        input  rden, addr, en, wr, busy, done, err
    );

    modport slave (
        input  start, len, ch_en, full, abort,
        output rden, addr, en, wr, busy, done, err
    );
endinterface

// File: rtl/front_end_mc.sv
// Burst sequencer: reads len words from input memory, advances a fixed-latency core
// and writes results to the masked output FIFOs, draining the pipe before done.
module front_end_mc #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic              aclk,
    input  logic              aresetn,
    front_end_mc_if.slave     bus
);

    typedef enum logic [2:0] {StIdle, StFirst, StRun, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]    en_cnt_q, en_cnt_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [N_CH-1:0]     mask_q, mask_d;
    logic [PIPE_LAT-1:0] vld_q, vld_d;
    logic                err_q, err_d;

    logic                stall;
    logic                tail;
    logic [PIPE_LAT-1:0] vld_run;
    logic [PIPE_LAT-1:0] vld_drain;
    logic                rden, en, busy, done;
    logic [N_CH-1:0]     wr;

    // Stall uses the mask latched at start so a live ch_en change cannot disturb a burst.
    assign stall     = |(bus.full & mask_q);
    assign tail      = vld_q[PIPE_LAT-1];
    // Shift images: RUN shifts in a 1 (en is high whenever a shift happens), DRAIN a 0.
    assign vld_run   = (vld_q << 1) | PIPE_LAT'(1);
    assign vld_drain = vld_q << 1;

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        en_cnt_d = en_cnt_q;
        len_d    = len_q;
        mask_d   = mask_q;
        vld_d    = vld_q;
        err_d    = err_q;
        rden     = 1'b0;
        en       = 1'b0;
        wr       = '0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        state_d  = StFirst;
                        len_d    = bus.len;
                        mask_d   = bus.ch_en;
                        rd_cnt_d = '0;
                        en_cnt_d = '0;
                        err_d    = 1'b0;
                    end else begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StFirst, StRun, StDrain: begin
                busy = 1'b1;
                if (bus.abort) begin
                    vld_d   = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (state_q == StFirst) begin
                    rden     = 1'b1;
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    state_d  = StRun;
                end else begin
                    wr = {N_CH{tail && !stall}} & mask_q;
                    if (state_q == StRun) begin
                        en   = !stall;
                        rden = !stall && (rd_cnt_q < len_q);
                        if (rden) rd_cnt_d = rd_cnt_q + CNT_W'(1);
                        if (!stall) vld_d = vld_run;
                        if (en) begin
                            en_cnt_d = en_cnt_q + CNT_W'(1);
                            if (en_cnt_q == len_q - CNT_W'(1)) state_d = StDrain;
                        end
                    end else if (!stall) begin
                        vld_d = vld_drain;
                        if (vld_drain == '0) state_d = StDone;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= StIdle;
            rd_cnt_q <= '0;
            en_cnt_q <= '0;
            len_q    <= '0;
            mask_q   <= '0;
            vld_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            en_cnt_q <= en_cnt_d;
            len_q    <= len_d;
            mask_q   <= mask_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    assign bus.rden = rden;
    assign bus.addr = busy ? rd_cnt_q : '0;
    assign bus.en   = en;
    assign bus.wr   = wr;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_front_end_mc.sv
// Self-checking bench: a word-level pipeline model predicts every output each cycle,
// and per-scenario literal checks pin burst timing and write counts.
module tb_front_end_mc;
    localparam int N_CH     = 2;
    localparam int CNT_W    = 16;
    localparam int PIPE_LAT = 2;

    localparam int PH_IDLE  = 0;
    localparam int PH_FIRST = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_DRAIN = 3;
    localparam int PH_DONE  = 4;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    front_end_mc_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    front_end_mc #(.N_CH(N_CH), .CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge aclk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model state: each in-flight word carries how many pipeline shifts it has seen.
    int              m_ph = PH_IDLE;
    int              m_len, m_rd, m_en, old_ph;
    logic [N_CH-1:0] m_mask;
    logic            m_err;
    int              age_q[$];
    int              nq[$];
    logic            e_stall, e_tail, e_act, e_rden, e_en, e_busy, e_done;
    logic [N_CH-1:0] e_wr;
    int              e_addr;

    // Per-burst observations, relative to the start cycle t0.
    int t0, n_wr0, n_wr1, n_rden, n_en, n_busy, n_done, done_rel, err_done, first_wr, last_wr;

    task automatic clear_stats();
        t0 = cyc; n_wr0 = 0; n_wr1 = 0; n_rden = 0; n_en = 0; n_busy = 0; n_done = 0;
        done_rel = -1; err_done = -1; first_wr = -1; last_wr = -1;
    endtask

    always @(negedge aclk) begin
        if (!aresetn) begin
            m_ph = PH_IDLE; m_len = 0; m_rd = 0; m_en = 0; m_mask = '0; m_err = 1'b0;
            age_q = {};
            e_rden = 0; e_en = 0; e_wr = '0; e_busy = 0; e_done = 0; e_addr = 0;
        end else begin
            e_stall = |(bus.full & m_mask);
            e_tail  = 1'b0;
            foreach (age_q[i]) if (age_q[i] == PIPE_LAT) e_tail = 1'b1;
            e_act  = (m_ph == PH_FIRST) || (m_ph == PH_RUN) || (m_ph == PH_DRAIN);
            e_busy = e_act;
            e_done = (m_ph == PH_DONE);
            e_addr = e_act ? m_rd : 0;
            e_rden = 0; e_en = 0; e_wr = '0;
            if (e_act && !bus.abort) begin
                if (m_ph == PH_FIRST) e_rden = 1;
                else begin
                    if (m_ph == PH_RUN) begin
                        e_en   = !e_stall;
                        e_rden = !e_stall && (m_rd < m_len);
                    end
                    if (!e_stall && e_tail) e_wr = m_mask;
                end
            end
        end

        chk("rden", int'(bus.rden), int'(e_rden));
        chk("en",   int'(bus.en),   int'(e_en));
        chk("wr",   int'(bus.wr),   int'(e_wr));
        chk("busy", int'(bus.busy), int'(e_busy));
        chk("done", int'(bus.done), int'(e_done));
        chk("err",  int'(bus.err),  int'(m_err));
        chk("addr", int'(bus.addr), e_addr);

        if (bus.wr[0]) n_wr0++;
        if (bus.wr[1]) n_wr1++;
        if (bus.wr != '0) begin
            if (first_wr < 0) first_wr = cyc - t0;
            last_wr = cyc - t0;
        end
        if (bus.rden) n_rden++;
        if (bus.en) n_en++;
        if (bus.busy) n_busy++;
        if (bus.done) begin
            n_done++; done_rel = cyc - t0; err_done = int'(bus.err);
        end

        if (aresetn) begin
            old_ph = m_ph;
            case (old_ph)
                PH_IDLE: if (bus.start) begin
                    if (bus.len != 0) begin
                        m_ph = PH_FIRST; m_len = int'(bus.len); m_mask = bus.ch_en;
                        m_rd = 0; m_en = 0; m_err = 1'b0;
                    end else begin
                        m_ph = PH_DONE; m_err = 1'b1;
                    end
                end
                PH_DONE: m_ph = PH_IDLE;
                default: begin
                    if (bus.abort) begin
                        age_q = {}; m_err = 1'b1; m_ph = PH_DONE;
                    end else if (old_ph == PH_FIRST) begin
                        m_rd = 1; m_ph = PH_RUN;
                    end else begin
                        if (e_rden) m_rd++;
                        if (!e_stall) begin
                            nq = {};
                            foreach (age_q[i]) if (age_q[i] < PIPE_LAT) nq.push_back(age_q[i] + 1);
                            if (e_en) nq.push_back(1);
                            age_q = nq;
                        end
                        if (e_en) begin
                            m_en++;
                            if (m_en == m_len) m_ph = PH_DRAIN;
                        end
                        if (old_ph == PH_DRAIN && !e_stall && age_q.size() == 0) m_ph = PH_DONE;
                    end
                end
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Holds start for exactly one cycle; that cycle becomes relative cycle 0.
    task automatic launch(input int l, input logic [N_CH-1:0] m);
        bus.start = 1'b1;
        bus.len   = CNT_W'(l);
        bus.ch_en = m;
        clear_stats();
        tick(1);
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.len = '0; bus.ch_en = '0; bus.full = '0; bus.abort = 1'b0;
        clear_stats();
        tick(2);
        aresetn = 1'b1;
        tick(2);

        // Plain burst of four words.
        launch(4, 2'b11);
        tick(12);
        chk("s1_done_cycle", done_rel, 8);
        chk("s1_done_count", n_done, 1);
        chk("s1_err", err_done, 0);
        chk("s1_wr0_count", n_wr0, 4);
        chk("s1_wr1_count", n_wr1, 4);
        chk("s1_first_wr", first_wr, 4);
        chk("s1_last_wr", last_wr, 7);
        chk("s1_rden_count", n_rden, 4);
        chk("s1_en_count", n_en, 4);
        chk("s1_busy_count", n_busy, 7);

        // Channel 1 full during cycles 3-4.
        launch(4, 2'b11);
        tick(2);
        bus.full = 2'b10;
        tick(2);
        bus.full = 2'b00;
        tick(8);
        chk("s2_done_cycle", done_rel, 10);
        chk("s2_wr0_count", n_wr0, 4);
        chk("s2_wr1_count", n_wr1, 4);
        chk("s2_first_wr", first_wr, 6);
        chk("s2_last_wr", last_wr, 9);

        // Masked channel stays full throughout without stalling.
        bus.full = 2'b10;
        launch(4, 2'b01);
        tick(12);
        bus.full = 2'b00;
        chk("s3_done_cycle", done_rel, 8);
        chk("s3_wr0_count", n_wr0, 4);
        chk("s3_wr1_count", n_wr1, 0);
        chk("s3_first_wr", first_wr, 4);

        // Abort in cycle 4, then a fresh len=1 burst in cycle 7.
        launch(4, 2'b11);
        tick(3);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        tick(2);
        chk("s4_done_cycle", done_rel, 5);
        chk("s4_err", err_done, 1);
        chk("s4_wr_count", n_wr0 + n_wr1, 0);
        chk("s4_en_count", n_en, 2);
        chk("s4_rden_count", n_rden, 3);
        chk("s4_err_held_idle", int'(bus.err), 1);
        launch(1, 2'b11);
        chk("s4_err_cleared", int'(bus.err), 0);
        tick(8);
        chk("s4b_done_cycle", done_rel, 5);
        chk("s4b_err", err_done, 0);

        // Zero-length burst.
        launch(0, 2'b11);
        tick(4);
        chk("s5_done_cycle", done_rel, 1);
        chk("s5_err", err_done, 1);
        chk("s5_activity", n_rden + n_en + n_wr0 + n_wr1, 0);

        // Single-word burst.
        launch(1, 2'b11);
        tick(7);
        chk("s6_done_cycle", done_rel, 5);
        chk("s6_first_wr", first_wr, 4);
        chk("s6_wr0_count", n_wr0, 1);

        // Single-word burst cut by reset in cycle 3.
        launch(1, 2'b11);
        tick(2);
        aresetn = 1'b0;
        tick(2);
        aresetn = 1'b1;
        tick(6);
        chk("s6b_done_count", n_done, 0);
        chk("s6b_wr_count", n_wr0 + n_wr1, 0);
        chk("s6b_err", int'(bus.err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
